ssp_tx_serializer: RTL and testbench
====================================

Name: ssp_tx_serializer

Overview:
- Transmit-side serial engine of the SSP, directly downstream of the transmit FIFO.
- Pops 8-bit words from the FIFO using the ValidWord/NextWord handshake and shifts them out MSB-first.
- Frame format is TI synchronous serial: a one-bit-period SSPFSSOUT pulse precedes each word.
- Generates SSPCLKOUT at PCLK/2 and drives SSPOE_B for the pad tristate.

Parameters:
DATA_WIDTH, 8, word length in bits; sets the TxData width and the bit-counter range (bit counter is $clog2(DATA_WIDTH) wide).

Ports:
PCLK  input  1  system clock; all flops rise on PCLK.
CLEAR_B  input  1  asynchronous active-low reset.
ValidWord  input  1  FIFO has a word at its head on TxData.
TxData  input  DATA_WIDTH  head-of-FIFO word.
NextWord  output  1  one-PCLK pulse: FIFO pops its head word.
SSPCLKOUT  output  1  serial clock, PCLK/2, free-running.
SSPFSSOUT  output  1  frame sync pulse, one serial period, high before the MSB.
SSPTXD  output  1  serial data, MSB first.
SSPOE_B  output  1  active-low output enable for SSPTXD.

Behaviour:
- One clock (PCLK). Reset is asynchronous and active-low on CLEAR_B. All outputs and state are registered.
- Reset values: SSPCLKOUT=0, SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, NextWord=0, state=IDLE, shift register=0, bit counter=0.
- SSPCLKOUT toggles on every PCLK edge while CLEAR_B=1, so its period is 2 PCLK.
- Launch edge: a PCLK edge at which SSPCLKOUT is currently 0, i.e. it goes 0->1. All state, SSPFSSOUT, SSPTXD and SSPOE_B change only on launch edges. The external receiver samples on SSPCLKOUT falling.
- States and transitions:
  - IDLE: SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1. At a launch edge with ValidWord=1: latch TxData into the shift register, set SSPFSSOUT=1, go to SYNC. ValidWord is ignored on non-launch edges.
  - SYNC: one serial period with FSS high. At the next launch edge: SSPFSSOUT=0, SSPTXD=shift[MSB], SSPOE_B=0, bit counter=DATA_WIDTH-1, go to SHIFT.
  - SHIFT: each launch edge drives the next lower bit and decrements the counter.
- Last-bit launch edge: the launch edge that drives bit 0.
  - If ValidWord=1 there: latch the new TxData, and SSPFSSOUT=1 concurrently with bit 0. The following launch edge drives the new MSB, so words go back to back with no gap and SSPOE_B stays 0.
  - Otherwise, at the launch edge after bit 0: go to IDLE with SSPOE_B=1, SSPTXD=0.
- NextWord: high for exactly the one PCLK cycle following each latch edge; the FIFO pops at the edge that ends that cycle. Exactly one NextWord pulse per word transmitted; never asserted when ValidWord was 0 at the latch edge.
- ValidWord changes during SYNC and SHIFT (other than at the last-bit launch edge) have no effect.
- Frame timing:
  - Isolated word: 18 PCLK from latch edge to return to IDLE (2 SYNC + 16 data).
  - Back-to-back words: 16 PCLK per word.
- Latency: with ValidWord=1 at reset release, the first PCLK edge is a launch edge, so SSPFSSOUT is high after that edge and NextWord is high in the following cycle.
- Reset mid-frame: immediate abort to reset values. A word already popped is lost, and no NextWord is issued after reset.

Test Plan:
- Single word: ValidWord=1 with TxData=0xA5, dropped after NextWord -> one NextWord pulse; FSS high 2 PCLK; SSPTXD=1,0,1,0,0,1,0,1 at successive launch edges; SSPOE_B low 16 PCLK; back to IDLE 18 PCLK after the latch edge.
- Back-to-back: FIFO holds 0x3C then 0xC3 -> FSS high concurrently with bit 0 of 0x3C; 0xC3 MSB on the next launch edge; SSPOE_B continuously low for 32 PCLK; exactly 2 NextWord pulses.
- Late ValidWord: ValidWord rises 1 PCLK after the bit-0 launch edge -> no back-to-back; SSPOE_B returns to 1 for at least one serial period; the next frame starts with a fresh FSS pulse.
- Reset mid-frame: CLEAR_B low while shifting bit 4 of 0xFF -> all outputs take reset values immediately; after release with ValidWord=0, the bench observes SSPOE_B=1 and no NextWord.
- Idle: ValidWord=0 for 100 PCLK -> SSPCLKOUT toggles every PCLK; SSPFSSOUT=0, SSPTXD=0, SSPOE_B=1, NextWord=0 throughout.
- Mid-frame ValidWord glitch: ValidWord pulses during SHIFT of 0x81 -> no effect; serial stream stays 1,0,0,0,0,0,0,1 with a single NextWord pulse.

Source files
------------

// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: pops words from the TX FIFO and shifts them out
// MSB-first in TI synchronous serial format, with SSPCLKOUT at PCLK/2.
module ssp_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  ValidWord,
  input  logic [DATA_WIDTH-1:0] TxData,
  output logic                  NextWord,
  output logic                  SSPCLKOUT,
  output logic                  SSPFSSOUT,
  output logic                  SSPTXD,
  output logic                  SSPOE_B
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_MSB = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SYNC, SHIFT} state_t;

  state_t                state, state_nx;
  logic [DATA_WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic                  fss_nx, txd_nx, oe_b_nx;
  logic                  latch;
  logic                  launch;

  assign launch = ~SSPCLKOUT;

  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = cnt;
    fss_nx   = SSPFSSOUT;
    txd_nx   = SSPTXD;
    oe_b_nx  = SSPOE_B;
    latch    = 1'b0;
    if (launch) begin
      unique case (state)
        IDLE: begin
          fss_nx  = 1'b0;
          txd_nx  = 1'b0;
          oe_b_nx = 1'b1;
          if (ValidWord) begin
            shreg_nx = TxData;
            fss_nx   = 1'b1;
            latch    = 1'b1;
            state_nx = SYNC;
          end
        end
        SYNC: begin
          fss_nx   = 1'b0;
          txd_nx   = shreg[DATA_WIDTH-1];
          shreg_nx = shreg << 1;
          oe_b_nx  = 1'b0;
          cnt_nx   = CNT_MSB;
          state_nx = SHIFT;
        end
        SHIFT: begin
          if (cnt == '0) begin
            // FSS still high here means a follow-on word was latched with bit 0
            if (SSPFSSOUT) begin
              fss_nx   = 1'b0;
              txd_nx   = shreg[DATA_WIDTH-1];
              shreg_nx = shreg << 1;
              cnt_nx   = CNT_MSB;
            end else begin
              txd_nx   = 1'b0;
              oe_b_nx  = 1'b1;
              state_nx = IDLE;
            end
          end else begin
            txd_nx   = shreg[DATA_WIDTH-1];
            shreg_nx = shreg << 1;
            cnt_nx   = cnt - CW'(1);
            if (cnt == CW'(1) && ValidWord) begin
              shreg_nx = TxData;
              fss_nx   = 1'b1;
              latch    = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      SSPCLKOUT <= 1'b0;
      SSPFSSOUT <= 1'b0;
      SSPTXD    <= 1'b0;
      SSPOE_B   <= 1'b1;
      NextWord  <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      cnt       <= cnt_nx;
      SSPCLKOUT <= ~SSPCLKOUT;
      SSPFSSOUT <= fss_nx;
      SSPTXD    <= txd_nx;
      SSPOE_B   <= oe_b_nx;
      NextWord  <= latch;
    end
  end

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Bench for ssp_tx_serializer: directed FIFO stimulus with a serial-stream
// monitor that rebuilds words and checks them against a queue of expected words.
module tb_ssp_tx_serializer;
  localparam int DW = 8;

  logic          PCLK = 1'b0;
  logic          CLEAR_B = 1'b0;
  logic          ValidWord = 1'b0;
  logic [DW-1:0] TxData = '0;
  logic          NextWord, SSPCLKOUT, SSPFSSOUT, SSPTXD, SSPOE_B;

  int n_checks = 0;
  int n_pass = 0;
  logic [DW-1:0] exp_q[$];

  int s_idx = 0;
  int nw_cnt, fss_cnt, oe_lo_cnt, txd_hi_cnt, toggle_bad;
  int first_fss, oe_run, oe_run_max, oe_rise_idx, oe_gap;
  logic prev_sclk, prev_oe, prev_clr;

  ssp_tx_serializer #(.DATA_WIDTH(DW)) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .ValidWord (ValidWord),
    .TxData    (TxData),
    .NextWord  (NextWord),
    .SSPCLKOUT (SSPCLKOUT),
    .SSPFSSOUT (SSPFSSOUT),
    .SSPTXD    (SSPTXD),
    .SSPOE_B   (SSPOE_B)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic clear_stats();
    nw_cnt = 0; fss_cnt = 0; oe_lo_cnt = 0; txd_hi_cnt = 0; toggle_bad = 0;
    first_fss = -1; oe_run = 0; oe_run_max = 0; oe_rise_idx = -1; oe_gap = -1;
    prev_sclk = SSPCLKOUT; prev_oe = SSPOE_B; prev_clr = CLEAR_B;
  endtask

  // One PCLK: sample outputs on the falling edge, accumulate statistics.
  task automatic tick();
    @(negedge PCLK);
    s_idx++;
    if (NextWord) nw_cnt++;
    if (SSPFSSOUT) begin
      fss_cnt++;
      if (first_fss < 0) first_fss = s_idx;
    end
    if (SSPTXD) txd_hi_cnt++;
    if (!SSPOE_B) begin
      oe_lo_cnt++;
      oe_run++;
      if (oe_run > oe_run_max) oe_run_max = oe_run;
    end else oe_run = 0;
    if (!prev_oe && SSPOE_B) oe_rise_idx = s_idx;
    if (prev_oe && !SSPOE_B && oe_rise_idx >= 0 && oe_gap < 0) oe_gap = s_idx - oe_rise_idx;
    if (CLEAR_B && prev_clr && SSPCLKOUT == prev_sclk) toggle_bad++;
    prev_sclk = SSPCLKOUT; prev_oe = SSPOE_B; prev_clr = CLEAR_B;
  endtask

  task automatic wait_nw(input string name, input int lim);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!NextWord && n < lim);
    check(name, NextWord, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sclk"}, SSPCLKOUT, 0);
    check({tag, "_fss"},  SSPFSSOUT, 0);
    check({tag, "_txd"},  SSPTXD, 0);
    check({tag, "_oe_b"}, SSPOE_B, 1);
    check({tag, "_nw"},   NextWord, 0);
  endtask

  // Receiver model: one sample per serial period while SSPCLKOUT is high.
  int bits_left = 0;
  logic [DW-1:0] rx = '0;
  always @(negedge PCLK) begin
    if (!CLEAR_B) bits_left = 0;
    else if (SSPCLKOUT) begin
      if (bits_left > 0) begin
        rx = {rx[DW-2:0], SSPTXD};
        check("oe_in_word", SSPOE_B, 0);
        bits_left--;
        if (bits_left == 0) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL word_unexpected: got %02h, no word expected", rx);
          end else check("word", rx, exp_q.pop_front());
        end
        if (SSPFSSOUT) begin
          check("fss_only_on_last_bit", bits_left, 0);
          bits_left = DW;
        end
      end else if (SSPFSSOUT) bits_left = DW;
      else begin
        check("idle_txd", SSPTXD, 0);
        check("idle_oe_b", SSPOE_B, 1);
      end
    end
  end

  initial begin
    CLEAR_B = 1'b0;
    repeat (3) @(negedge PCLK);
    check_reset_values("reset");

    // Idle for 100 PCLK
    CLEAR_B = 1'b1;
    clear_stats();
    repeat (100) tick();
    check("idle_sclk_toggle_errs", toggle_bad, 0);
    check("idle_fss_cycles", fss_cnt, 0);
    check("idle_txd_cycles", txd_hi_cnt, 0);
    check("idle_oe_low_cycles", oe_lo_cnt, 0);
    check("idle_nw_pulses", nw_cnt, 0);

    // Single word 0xA5
    clear_stats();
    exp_q.push_back(8'hA5);
    ValidWord = 1'b1; TxData = 8'hA5;
    wait_nw("single_nw_seen", 10);
    ValidWord = 1'b0;
    repeat (30) tick();
    check("single_nw_pulses", nw_cnt, 1);
    check("single_fss_cycles", fss_cnt, 2);
    check("single_oe_low_cycles", oe_lo_cnt, 16);
    check("single_latch_to_idle", oe_rise_idx - first_fss, 18);

    // Back-to-back 0x3C, 0xC3
    clear_stats();
    exp_q.push_back(8'h3C); exp_q.push_back(8'hC3);
    ValidWord = 1'b1; TxData = 8'h3C;
    wait_nw("b2b_nw1_seen", 10);
    TxData = 8'hC3;
    wait_nw("b2b_nw2_seen", 40);
    ValidWord = 1'b0;
    repeat (40) tick();
    check("b2b_nw_pulses", nw_cnt, 2);
    check("b2b_fss_cycles", fss_cnt, 4);
    check("b2b_oe_low_run", oe_run_max, 32);
    check("b2b_oe_low_cycles", oe_lo_cnt, 32);

    // ValidWord rises one PCLK after the bit-0 launch edge
    clear_stats();
    exp_q.push_back(8'h96); exp_q.push_back(8'h69);
    ValidWord = 1'b1; TxData = 8'h96;
    wait_nw("late_nw1_seen", 10);
    ValidWord = 1'b0;
    while (s_idx < first_fss + 16) tick();
    ValidWord = 1'b1; TxData = 8'h69;
    wait_nw("late_nw2_seen", 10);
    ValidWord = 1'b0;
    repeat (40) tick();
    check("late_nw_pulses", nw_cnt, 2);
    check("late_fss_cycles", fss_cnt, 4);
    check("late_oe_low_run", oe_run_max, 16);
    check("late_oe_low_cycles", oe_lo_cnt, 32);
    check("late_oe_high_gap", oe_gap, 4);

    // Reset while bit 4 of 0xFF is on the line; that word is lost
    clear_stats();
    ValidWord = 1'b1; TxData = 8'hFF;
    wait_nw("rstmid_nw_seen", 10);
    ValidWord = 1'b0;
    while (s_idx < first_fss + 8) tick();
    check("rstmid_pre_txd", SSPTXD, 1);
    check("rstmid_pre_oe_b", SSPOE_B, 0);
    CLEAR_B = 1'b0;
    #1;
    check_reset_values("rstmid");
    repeat (3) @(negedge PCLK);
    CLEAR_B = 1'b1;
    clear_stats();
    repeat (20) tick();
    check("rstmid_post_nw_pulses", nw_cnt, 0);
    check("rstmid_post_oe_low_cycles", oe_lo_cnt, 0);
    check("rstmid_post_fss_cycles", fss_cnt, 0);
    check("rstmid_post_sclk_toggle_errs", toggle_bad, 0);

    // ValidWord glitch during SHIFT of 0x81
    clear_stats();
    exp_q.push_back(8'h81);
    ValidWord = 1'b1; TxData = 8'h81;
    wait_nw("glitch_nw_seen", 10);
    ValidWord = 1'b0;
    while (s_idx < first_fss + 6) tick();
    ValidWord = 1'b1; TxData = 8'h00;
    tick(); tick();
    ValidWord = 1'b0;
    repeat (30) tick();
    check("glitch_nw_pulses", nw_cnt, 1);
    check("glitch_fss_cycles", fss_cnt, 2);
    check("glitch_oe_low_cycles", oe_lo_cnt, 16);

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
